// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and types; instruction memory indexes words with pc[4:1]
// using these same widths.
package cpu_pkg;
   localparam int PC_W        = 16;
   localparam int INSTR_W     = 16;
   localparam int INSTR_BYTES = 2;

   typedef logic [PC_W-1:0]    pc_t;
   typedef logic [INSTR_W-1:0] instr_t;

   localparam pc_t RESET_PC = 16'h0000;

   typedef struct packed {
      pc_t    pc;
      instr_t instr;
   } fetch_entry_t;

   // Instructions are halfword aligned, so bit 0 of any target is dropped.
   function automatic pc_t align_pc(input pc_t pc);
      return {pc[PC_W-1:1], 1'b0};
   endfunction

   function automatic pc_t next_seq_pc(input pc_t pc);
      return pc + pc_t'(INSTR_BYTES);
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x W circular FIFO with synchronous flush; head registered, 1 clk write-to-head.
// Backpressure: caller must not push when full unless popping on the same edge; no empty bypass.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  logic [W-1:0]           i_dat,
   output logic [W-1:0]           o_head_dat,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + AW'(1);
         if (i_pop)  r_rptr <= r_rptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wptr] <= i_dat;
   end

   assign o_head_dat = r_mem[r_rptr];
   assign o_count    = r_count;
   assign o_full     = (r_count == (AW+1)'(DEPTH));
   assign o_empty    = (r_count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, drives imem_pc, buffers {pc,instr} for decode; 1 clk push-to-id_valid.
// Holds PC when buffer full and decode stalls; redirect flushes and overrides push/pop.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    imem_pc,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc
);
   pc_t                   r_fetch_pc;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [$clog2(DEPTH):0] w_count;
   fetch_entry_t          w_tail;
   fetch_entry_t          w_head;

   // Redirect wins: the head is flushed rather than consumed even with id_ready high.
   assign w_pop  = id_valid & id_ready & ~redirect_valid;
   assign w_push = ~redirect_valid & (~w_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_fetch_pc <= RESET_PC;
      else if (redirect_valid)
         r_fetch_pc <= align_pc(redirect_pc);
      else if (w_push)
         r_fetch_pc <= next_seq_pc(r_fetch_pc);
   end

   assign imem_pc = r_fetch_pc;
   assign w_tail  = '{pc: r_fetch_pc, instr: imem_instr};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_fetch_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_flush    (redirect_valid),
      .i_dat      (w_tail),
      .o_head_dat (w_head),
      .o_count    (w_count),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign id_valid = (w_count != '0);
   assign id_instr = w_empty ? '0 : w_head.instr;
   assign id_pc    = w_empty ? '0 : w_head.pc;
endmodule
